// File: rtl/isa_pkg.sv
// ISA definitions shared by the decode stage: opcodes, instruction field
// positions and the decoded-entry types that travel through the stage.
package isa_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_COMPI = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h03;
  localparam logic [5:0] OP_SW    = 6'h04;
  localparam logic [5:0] OP_BZ    = 6'h05;
  localparam logic [5:0] OP_BNZ   = 6'h06;
  localparam logic [5:0] OP_BLTZ  = 6'h07;
  localparam logic [5:0] OP_BGTZ  = 6'h08;
  localparam logic [5:0] OP_JUMP  = 6'h09;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int SHAMT_MSB  = 15;
  localparam int SHAMT_LSB  = 11;
  localparam int FUNCT_MSB  = 4;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;
  } fields_t;

  // Flags are resolved once at storage-write time and carried with the fields.
  typedef struct packed {
    fields_t fields;
    logic    is_imm;
    logic    is_jump;
  } entry_t;

  function automatic logic opcode_is_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_COMPI, OP_LW, OP_SW,
      OP_BZ, OP_BNZ, OP_BLTZ, OP_BGTZ: return 1'b1;
      OP_RTYPE, OP_JUMP:               return 1'b0;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = the fetch/execute environment, slave = the decode stage itself.
interface id_decode_stage_if
  import isa_pkg::*;
#(
  parameter int PC_W = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [5:0]         out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_shamt;
  logic [4:0]         out_funct;
  logic [15:0]        out_imm16;
  logic [25:0]        out_target;
  logic               out_is_imm;
  logic               out_is_jump;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt,
           out_shamt, out_funct, out_imm16, out_target, out_is_imm, out_is_jump
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt,
           out_shamt, out_funct, out_imm16, out_target, out_is_imm, out_is_jump
  );

endinterface

// File: rtl/id_field_decode.sv
// Purely combinational split of an instruction word into its fields plus
// the immediate-class and jump flags.
module id_field_decode
  import isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output fields_t            fields,
  output logic               is_imm,
  output logic               is_jump
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    fields.rs     = instr[RS_MSB:RS_LSB];
    fields.rt     = instr[RT_MSB:RT_LSB];
    fields.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    fields.funct  = instr[FUNCT_MSB:FUNCT_LSB];
    fields.imm16  = instr[IMM_MSB:IMM_LSB];
    fields.target = instr[TARGET_MSB:TARGET_LSB];
    is_imm        = opcode_is_imm(fields.opcode);
    is_jump       = (fields.opcode == OP_JUMP);
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: 2-entry skid buffer (skid -> main) between fetch and execute,
// with per-entry field decode and a wrapping issued-instruction counter.
module id_decode_stage
  import isa_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] issue_cnt
);

  entry_t          in_entry;
  fields_t         dec_fields;
  logic            dec_is_imm;
  logic            dec_is_jump;

  entry_t          skid_entry_p0;
  logic [PC_W-1:0] skid_pc_p0;
  logic            skid_vld_p0;

  entry_t          main_entry_p1;
  logic [PC_W-1:0] main_pc_p1;
  logic            main_vld_p1;

  logic [CNT_W-1:0] cnt;

  logic in_xfer;
  logic out_xfer;
  logic main_free;

  // Both storage write points take the same freshly decoded input entry.
  id_field_decode u_field_decode (
    .instr   (bus.in_instr),
    .fields  (dec_fields),
    .is_imm  (dec_is_imm),
    .is_jump (dec_is_jump)
  );

  always_comb begin
    in_entry         = '0;
    in_entry.fields  = dec_fields;
    in_entry.is_imm  = dec_is_imm;
    in_entry.is_jump = dec_is_jump;
  end

  // Ready comes straight from a flop so out_ready never reaches in_ready.
  assign bus.in_ready = !skid_vld_p0;
  assign in_xfer      = bus.in_valid && !skid_vld_p0;
  assign out_xfer     = main_vld_p1 && bus.out_ready;
  assign main_free    = !main_vld_p1 || bus.out_ready;

  // Stage p0 -> p1: valid bits and issue counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p0 <= 1'b0;
      cnt         <= '0;
    end else begin
      if (out_xfer) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (flush) begin
        main_vld_p1 <= 1'b0;
        skid_vld_p0 <= 1'b0;
      end else if (main_free) begin
        main_vld_p1 <= skid_vld_p0 || in_xfer;
        skid_vld_p0 <= 1'b0;
      end else if (in_xfer) begin
        skid_vld_p0 <= 1'b1;
      end
    end
  end

  // Stage p0 -> p1: entry payloads (held unchanged whenever not written)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_entry_p1 <= '0;
      main_pc_p1    <= '0;
      skid_entry_p0 <= '0;
      skid_pc_p0    <= '0;
    end else if (!flush) begin
      if (main_free) begin
        if (skid_vld_p0) begin
          main_entry_p1 <= skid_entry_p0;
          main_pc_p1    <= skid_pc_p0;
        end else if (in_xfer) begin
          main_entry_p1 <= in_entry;
          main_pc_p1    <= bus.in_pc;
        end
      end else if (in_xfer) begin
        skid_entry_p0 <= in_entry;
        skid_pc_p0    <= bus.in_pc;
      end
    end
  end

  assign bus.out_valid   = main_vld_p1;
  assign bus.out_pc      = main_pc_p1;
  assign bus.out_opcode  = main_entry_p1.fields.opcode;
  assign bus.out_rs      = main_entry_p1.fields.rs;
  assign bus.out_rt      = main_entry_p1.fields.rt;
  assign bus.out_shamt   = main_entry_p1.fields.shamt;
  assign bus.out_funct   = main_entry_p1.fields.funct;
  assign bus.out_imm16   = main_entry_p1.fields.imm16;
  assign bus.out_target  = main_entry_p1.fields.target;
  assign bus.out_is_imm  = main_entry_p1.is_imm;
  assign bus.out_is_jump = main_entry_p1.is_jump;
  assign issue_cnt       = cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed + randomized bench for id_decode_stage; the reference is a plain
// two-deep FIFO of (instr, pc) with fields recomputed by shifting and masking.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] issue_cnt;

  id_decode_stage_if #(.PC_W(32)) bus();

  id_decode_stage #(.PC_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .flush     (flush),
    .bus       (bus),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  txn_t        q[$];
  int          cnt_model = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_seq = 32'h0000_1000;
  logic [31:0] pc_a;
  logic [31:0] pc_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic r, input logic f);
    pc_seq        = pc_seq + 32'd4;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc_seq;
    bus.out_ready = r;
    flush         = f;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'($urandom_range(0, 12));
    return w;
  endfunction

  // Advance one clock and apply the FIFO model to what was presented at that edge.
  task automatic tick();
    bit ox;
    bit ix;
    @(posedge clk);
    if (rst_n) begin
      ox = (q.size() > 0) && bus.out_ready;
      ix = bus.in_valid && (q.size() < 2);
      if (ox) cnt_model++;
      if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back('{bus.in_instr, bus.in_pc});
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    txn_t e;
    int   op;
    chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'(q.size() < 2));
    chk({tag, "/out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, "/issue_cnt"}, 64'(issue_cnt), 64'(cnt_model % 65536));
    if (q.size() > 0) begin
      e  = q[0];
      op = int'(e.instr >> 26);
      chk({tag, "/pc"},     64'(bus.out_pc),     64'(e.pc));
      chk({tag, "/opcode"}, 64'(bus.out_opcode), 64'(op));
      chk({tag, "/rs"},     64'(bus.out_rs),     64'((e.instr >> 21) & 32'h1F));
      chk({tag, "/rt"},     64'(bus.out_rt),     64'((e.instr >> 16) & 32'h1F));
      chk({tag, "/shamt"},  64'(bus.out_shamt),  64'((e.instr >> 11) & 32'h1F));
      chk({tag, "/funct"},  64'(bus.out_funct),  64'(e.instr & 32'h1F));
      chk({tag, "/imm16"},  64'(bus.out_imm16),  64'(e.instr & 32'hFFFF));
      chk({tag, "/target"}, 64'(bus.out_target), 64'(e.instr & 32'h03FF_FFFF));
      chk({tag, "/is_imm"}, 64'(bus.out_is_imm), 64'(op >= 1 && op <= 8));
      chk({tag, "/is_jump"}, 64'(bus.out_is_jump), 64'(op == 9));
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst/in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst/issue_cnt", 64'(issue_cnt),     64'd0);
    chk("rst/opcode",    64'(bus.out_opcode), 64'd0);
    chk("rst/imm16",     64'(bus.out_imm16), 64'd0);
    chk("rst/pc",        64'(bus.out_pc),    64'd0);
    chk("rst/is_imm",    64'(bus.out_is_imm), 64'd0);

    // First ADDI
    drive(1'b1, 32'h0441_FFF0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("addi/out_valid", 64'(bus.out_valid), 64'd1);
    chk("addi/opcode",    64'(bus.out_opcode), 64'h01);
    chk("addi/rs",        64'(bus.out_rs), 64'd2);
    chk("addi/rt",        64'(bus.out_rt), 64'd1);
    chk("addi/imm16",     64'(bus.out_imm16), 64'hFFF0);
    chk("addi/is_imm",    64'(bus.out_is_imm), 64'd1);
    check_model("addi");
    tick();
    chk("addi/issue_cnt", 64'(issue_cnt), 64'd1);
    check_model("addi_done");

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rand_instr(), 1'b1, 1'b0);
      tick();
      chk("stream/in_ready", 64'(bus.in_ready), 64'd1);
      check_model("stream");
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("stream/issue_cnt", 64'(issue_cnt), 64'd9);
    check_model("stream_end");

    // Backpressure: A then B with out_ready low
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    pc_a = bus.in_pc;
    tick();
    check_model("bp_a");
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    pc_b = bus.in_pc;
    tick();
    chk("bp/hold_pc",  64'(bus.out_pc), 64'(pc_a));
    chk("bp/in_ready", 64'(bus.in_ready), 64'd0);
    check_model("bp_b");
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    chk("bp/still_pc", 64'(bus.out_pc), 64'(pc_a));
    check_model("bp_hold");
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("bp/next_pc", 64'(bus.out_pc), 64'(pc_b));
    check_model("bp_drain1");
    tick();
    chk("bp/empty", 64'(bus.out_valid), 64'd0);
    check_model("bp_drain2");

    // Flush with both entries full and C offered
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    check_model("fl_full");
    drive(1'b1, rand_instr(), 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl/out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl/in_ready",  64'(bus.in_ready), 64'd1);
    check_model("fl_after");
    repeat (3) begin
      tick();
      chk("fl/no_c", 64'(bus.out_valid), 64'd0);
      check_model("fl_quiet");
    end

    // Flush coinciding with an accepted input
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_instr(), 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl2/out_valid", 64'(bus.out_valid), 64'd0);
    check_model("fl2");

    // Asynchronous reset with skid full
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    drive(1'b1, rand_instr(), 1'b0, 1'b0);
    tick();
    chk("ar/skid_full", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar/out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar/issue_cnt", 64'(issue_cnt), 64'd0);
    chk("ar/in_ready",  64'(bus.in_ready), 64'd1);
    q.delete();
    cnt_model = 0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      chk("ar/no_stale", 64'(bus.out_valid), 64'd0);
      check_model("ar_after");
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, rand_instr(), ($urandom % 3) != 0, ($urandom % 20) == 0);
      tick();
      check_model("rand");
    end

    // Counter wrap: fresh reset, then 65535 transfers and one more
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    q.delete();
    cnt_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70000 && cnt_model < 65535; i++) begin
      drive(1'b1, rand_instr(), 1'b1, 1'b0);
      tick();
    end
    chk("wrap/max", 64'(issue_cnt), 64'hFFFF);
    drive(1'b1, rand_instr(), 1'b1, 1'b0);
    tick();
    chk("wrap/zero", 64'(issue_cnt), 64'd0);
    check_model("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
